// File: rtl/sort_pkg.sv
// sort_pkg: state encoding, default sizes and watchdog limit shared by the
// sort feeder and its FIFO.
package sort_pkg;

  // Sequencer states of the feeder
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_SEND,
    S_DRAIN
  } state_e;

  localparam int WORD_SIZE_DEF = 4;
  localparam int VEC_LEN_DEF   = 8;

  // Watchdog terminal count (only used when SORT_TIMEOUT_EN is defined)
  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

endpackage

// File: rtl/sort_feeder_fifo.sv
// sort_feeder_fifo: synchronous FIFO with registered not-full flag,
// combinational head word, empty flag and occupancy count.
module sort_feeder_fifo
  import sort_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE_DEF,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             rd_pop,
  output logic [WIDTH-1:0] rd_head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push = wr_valid && ready_q;
  assign pop  = rd_pop && (count_q != '0);

  // Occupancy next state; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array: written on push, no reset so it maps to RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers (wrap naturally at power-of-two depth), count and not-full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

  assign wr_ready = ready_q;
  assign rd_head  = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/sort_feeder.sv
// sort_feeder: buffers an unframed word stream and sequences the bubble-sort
// engine one VEC_LEN-word vector at a time (load, sort, wait, send, drain).
// Optional build macro SORT_TIMEOUT_EN adds a 16-bit wait watchdog.
module sort_feeder
  import sort_pkg::*;
#(
  parameter int word_size  = WORD_SIZE_DEF,
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_CYC  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 Load,
  output logic                 Sort,
  output logic                 Send,
  output logic [word_size-1:0] Data_in,
  input  logic                 Ready,
  input  logic                 Busy,
  input  logic                 Waiting,
  output logic                 vec_done,
  output logic [7:0]           vec_count,
  output logic                 err
);

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0]  LAST_WORD  = 5'(VEC_LEN - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYC);

  state_e               state_q;
  logic [4:0]           wcnt_q;
  logic [7:0]           drain_q;
  logic                 load_q;
  logic                 sort_q;
  logic                 send_q;
  logic [word_size-1:0] data_q;
  logic                 vec_done_q;
  logic [7:0]           vec_count_q;
  logic                 err_q;

  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [word_size-1:0] fifo_head;
  logic                 pop;
  logic                 wd_fire;

  sort_feeder_fifo #(
    .WIDTH (word_size),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (in_data),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .rd_pop   (pop),
    .rd_head  (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A word leaves the FIFO only while loading and the sorter is accepting
  assign pop = (state_q == S_LOAD) && !fifo_empty && Ready;

`ifdef SORT_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  assign wd_fire = in_wait && (wd_q == WD_LIMIT);

  // Watchdog: counts cycles spent waiting on the sorter, cleared elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else if (in_wait) begin
      if (!wd_fire) begin
        wd_q <= wd_q + 16'd1;
      end
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Sequencer with registered sorter controls, status and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      drain_q     <= '0;
      load_q      <= 1'b0;
      sort_q      <= 1'b0;
      send_q      <= 1'b0;
      data_q      <= '0;
      vec_done_q  <= 1'b0;
      vec_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      load_q     <= 1'b0;
      sort_q     <= 1'b0;
      send_q     <= 1'b0;
      vec_done_q <= 1'b0;
      // The sorter must not claim to be busy before it has been started
      if (Busy && (state_q == S_IDLE || state_q == S_LOAD)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          wcnt_q <= '0;
          if ((fifo_count != '0) && Ready) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (pop) begin
            load_q <= 1'b1;
            data_q <= fifo_head;
            wcnt_q <= wcnt_q + 5'd1;
            if (wcnt_q == LAST_WORD) begin
              state_q <= S_START;
            end
          end
        end
        S_START: begin
          sort_q  <= 1'b1;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (wd_fire) begin
            err_q   <= 1'b1;
            state_q <= S_SEND;
          end else if (Waiting) begin
            state_q <= S_SEND;
          end else if (Busy) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (wd_fire) begin
            err_q   <= 1'b1;
            state_q <= S_SEND;
          end else if (Waiting) begin
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          send_q  <= 1'b1;
          drain_q <= '0;
          if (!Waiting) begin
            err_q <= 1'b1;
          end
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_q != DRAIN_LAST) begin
            drain_q <= drain_q + 8'd1;
          end else if (Ready) begin
            vec_done_q  <= 1'b1;
            vec_count_q <= vec_count_q + 8'd1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Load      = load_q;
  assign Sort      = sort_q;
  assign Send      = send_q;
  assign Data_in   = data_q;
  assign vec_done  = vec_done_q;
  assign vec_count = vec_count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sort_feeder.sv
// tb_sort_feeder: directed bench for sort_feeder with a cycle-level sorter
// model driven from the stimulus thread.
module tb_sort_feeder;

  localparam int W  = 4;
  localparam int VL = 8;
  localparam int FD = 16;
  localparam int DC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         Load;
  logic         Sort;
  logic         Send;
  logic [W-1:0] Data_in;
  logic         Ready;
  logic         Busy;
  logic         Waiting;
  logic         vec_done;
  logic [7:0]   vec_count;
  logic         err;

  always #5 clk = ~clk;

  sort_feeder #(
    .word_size  (W),
    .VEC_LEN    (VL),
    .FIFO_DEPTH (FD),
    .DRAIN_CYC  (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Load      (Load),
    .Sort      (Sort),
    .Send      (Send),
    .Data_in   (Data_in),
    .Ready     (Ready),
    .Busy      (Busy),
    .Waiting   (Waiting),
    .vec_done  (vec_done),
    .vec_count (vec_count),
    .err       (err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // producer queue and observed traffic
  int src_q[$];
  int ld_data[$];
  int ld_cyc[$];
  int sort_n = 0;
  int send_n = 0;
  int done_n = 0;

  // sorter model: 0 ready, 1 busy, 2 waiting, 3 streaming out
  int sm = 0;
  int sm_cnt = 0;
  int stall = 0;
  int stall_after = 0;
  int loads_in_vec = 0;
  bit busy_hold = 0;
  bit force_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // passive monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (Load) begin
        ld_data.push_back(int'(Data_in));
        ld_cyc.push_back(cyc);
        $display("[%0d] load data=%0d", cyc, Data_in);
      end
      if (Sort) sort_n++;
      if (Send) send_n++;
      if (vec_done) begin
        done_n++;
        $display("[%0d] vector done count=%0d", cyc, vec_count);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: retire accepted producer word, advance sorter model, drive inputs
  task automatic tick();
    bit acc;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    if (Sort) begin
      loads_in_vec = 0;
    end else if (Load) begin
      loads_in_vec++;
      if (stall_after != 0 && loads_in_vec == stall_after) begin
        stall = 5;
        stall_after = 0;
      end
    end
    case (sm)
      0: if (Sort) begin sm = 1; sm_cnt = 3; end
      1: if (!busy_hold) begin
           if (sm_cnt == 0) sm = 2;
           else sm_cnt--;
         end
      2: if (Send) begin sm = 3; sm_cnt = VL; end
      default: if (sm_cnt == 0) sm = 0; else sm_cnt--;
    endcase
    if (stall > 0) begin
      Ready = 1'b0;
      stall--;
    end else begin
      Ready = (sm == 0);
    end
    Busy    = (sm == 1) || force_busy;
    Waiting = (sm == 2);
    in_valid = (src_q.size() > 0);
    in_data  = in_valid ? W'(src_q[0]) : '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_n < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done_n, target);
  endtask

  task automatic model_reset();
    sm = 0; sm_cnt = 0; stall = 0; stall_after = 0; loads_in_vec = 0;
    busy_hold = 0; force_busy = 0;
    src_q.delete();
    in_valid = 1'b0; in_data = '0;
    Ready = 1'b1; Busy = 1'b0; Waiting = 1'b0;
  endtask

  int v1[8] = '{3, 1, 7, 0, 5, 2, 6, 4};
  int v2[8] = '{10, 11, 12, 13, 14, 15, 1, 2};
  int v4[8] = '{9, 8, 7, 6, 5, 4, 3, 2};
  int yv[20];
  int pads[4] = '{15, 14, 13, 12};
  int base;
  int guard;

  initial begin
    model_reset();
    rst = 1'b1;

    // ---- reset state ----
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_load", Load, 0);
    chk("rst_sort", Sort, 0);
    chk("rst_send", Send, 0);
    chk("rst_data_in", Data_in, 0);
    chk("rst_vec_done", vec_done, 0);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();

    // ---- vector 1: back-to-back stream, ideal sorter ----
    ld_data.delete(); ld_cyc.delete(); sort_n = 0; send_n = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(v1[i]);
    run_until_done(1, 200, "v1_done_reached");
    ticks(3);
    chk("v1_load_cnt", ld_data.size(), 8);
    for (int i = 0; i < 8 && i < ld_data.size(); i++) chk($sformatf("v1_word%0d", i), ld_data[i], v1[i]);
    if (ld_cyc.size() == 8) chk("v1_load_span", ld_cyc[7] - ld_cyc[0], 7);
    chk("v1_sort_pulses", sort_n, 1);
    chk("v1_send_pulses", send_n, 1);
    chk("v1_done_once", done_n, 1);
    chk("v1_vec_count", vec_count, 1);
    chk("v1_err", err, 0);

    // ---- vector 2: Ready low 5 cycles after the third Load ----
    ld_data.delete(); ld_cyc.delete();
    stall_after = 3;
    for (int i = 0; i < 8; i++) src_q.push_back(v2[i]);
    run_until_done(2, 200, "v2_done_reached");
    chk("v2_load_cnt", ld_data.size(), 8);
    for (int i = 0; i < 8 && i < ld_data.size(); i++) chk($sformatf("v2_word%0d", i), ld_data[i], v2[i]);
    if (ld_cyc.size() == 8) begin
      chk("v2_gap_before_stall", ld_cyc[2] - ld_cyc[1], 1);
      chk("v2_stall_gap", ld_cyc[3] - ld_cyc[2], 6);
      chk("v2_tail_span", ld_cyc[7] - ld_cyc[3], 4);
    end
    chk("v2_vec_count", vec_count, 2);
    chk("v2_err", err, 0);

    // ---- FIFO fill while the sorter is held in Busy ----
    ld_data.delete(); sort_n = 0;
    base = done_n;
    busy_hold = 1;
    for (int i = 0; i < 8; i++) src_q.push_back(i);
    guard = 0;
    while (sort_n == 0 && guard < 100) begin tick(); guard++; end
    chk("fill_sort_seen", sort_n, 1);
    ticks(5);
    for (int i = 0; i < 20; i++) begin
      yv[i] = (i * 3 + 1) % 16;
      src_q.push_back(yv[i]);
    end
    ticks(40);
    chk("fill_in_ready_low", in_ready, 0);
    chk("fill_pending", src_q.size(), 4);
    chk("fill_no_extra_load", ld_data.size(), 8);
    chk("fill_busy_no_err", err, 0);
    busy_hold = 0;
    for (int i = 0; i < 4; i++) src_q.push_back(pads[i]);
    run_until_done(base + 4, 800, "fill_done_reached");
    chk("fill_load_cnt", ld_data.size(), 32);
    if (ld_data.size() == 32) begin
      for (int i = 0; i < 20; i++) chk($sformatf("fill_word%0d", i), ld_data[8 + i], yv[i]);
      for (int i = 0; i < 4; i++) chk($sformatf("fill_pad%0d", i), ld_data[28 + i], pads[i]);
    end
    chk("fill_vec_count", vec_count, 6);
    chk("fill_err", err, 0);

    // ---- reset during WAIT_DONE ----
    sort_n = 0;
    busy_hold = 1;
    for (int i = 0; i < 11; i++) src_q.push_back(i + 2);
    guard = 0;
    while (sort_n == 0 && guard < 100) begin tick(); guard++; end
    chk("mid_sort_seen", sort_n, 1);
    ticks(4);
    chk("mid_busy_seen", Busy, 1);
    rst = 1'b1;
    model_reset();
    tick();
    chk("mid_rst_load", Load, 0);
    chk("mid_rst_sort", Sort, 0);
    chk("mid_rst_send", Send, 0);
    chk("mid_rst_data_in", Data_in, 0);
    chk("mid_rst_vec_done", vec_done, 0);
    chk("mid_rst_vec_count", vec_count, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    rst = 1'b0;
    ld_data.delete();
    ticks(20);
    chk("mid_fifo_empty", ld_data.size(), 0);
    base = done_n;
    for (int i = 0; i < 8; i++) src_q.push_back(v4[i]);
    run_until_done(base + 1, 200, "post_rst_done_reached");
    chk("post_rst_load_cnt", ld_data.size(), 8);
    for (int i = 0; i < 8 && i < ld_data.size(); i++) chk($sformatf("post_rst_word%0d", i), ld_data[i], v4[i]);
    chk("post_rst_vec_count", vec_count, 1);
    chk("post_rst_err", err, 0);

    // ---- Busy while IDLE sets the sticky error ----
    ticks(3);
    force_busy = 1;
    Busy = 1'b1;
    ticks(2);
    chk("idle_busy_err", err, 1);
    force_busy = 0;
    ticks(6);
    chk("err_sticky", err, 1);
    rst = 1'b1;
    model_reset();
    tick();
    chk("err_cleared_by_rst", err, 0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_feeder.md
Name: sort_feeder

Overview:
- Upstream front-end for the bubble-sort engine.
- Accepts an unframed valid/ready word stream into a small FIFO and slices it into VEC_LEN-word vectors.
- For each vector it sequences the sorter: load words, start the sort, wait for completion, then trigger the send.
- Decouples bursty producers from the sorter's Ready/Busy/Waiting handshake.

Parameters:
- word_size, 4, width of one data word; matches the sorter.
- VEC_LEN, 8, words per vector; must equal the sorter array size. Range 2..16.
- FIFO_DEPTH, 16, input buffer entries. Power of two, >= VEC_LEN.
- DRAIN_CYC, 8, cycles reserved after Send for the sorter to stream its output.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  word_size  producer word.
- in_valid  in  1  producer word valid.
- in_ready  out  1  FIFO can accept a word.
- Load  out  1  to sorter: present Data_in this cycle.
- Sort  out  1  to sorter: one-cycle start pulse.
- Send  out  1  to sorter: one-cycle output request.
- Data_in  out  word_size  to sorter: word being loaded.
- Ready  in  1  from sorter: idle, accepts Load/Sort.
- Busy  in  1  from sorter: sorting.
- Waiting  in  1  from sorter: sorted, awaiting Send.
- vec_done  out  1  one-cycle pulse when a vector's drain completes.
- vec_count  out  8  vectors completed; wraps 255->0.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - FIFO is empty; in_ready=1.
  - Load, Sort, Send, vec_done, err = 0; Data_in=0; vec_count=0.
  - FSM is in IDLE.
  - Reset mid-vector discards buffered words and the partial load.
- FIFO:
  - Push when in_valid and in_ready.
  - in_ready = !full, registered; it does not depend on the same-cycle pop.
  - Simultaneous push and pop while non-full and non-empty: occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, SEND, DRAIN.
- IDLE -> LOAD when FIFO occupancy >= 1 and Ready=1.
- LOAD:
  - Each cycle with FIFO non-empty and Ready=1: Load=1, Data_in=FIFO head, pop, word counter +1.
  - If FIFO is empty or Ready=0: Load=0 and the counter holds (stall, no error).
  - After word VEC_LEN-1 is loaded, go to START.
- START: Sort=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY:
  - Leave on Busy=1 -> WAIT_DONE.
  - If Waiting=1 arrives directly (trivial sort), go straight to SEND.
- WAIT_DONE: on Waiting=1 -> SEND.
- SEND: Send=1 for one cycle, then DRAIN.
- DRAIN:
  - Count DRAIN_CYC cycles, then require Ready=1.
  - Then pulse vec_done, increment vec_count, return to IDLE.
- err is set (sticky until rst) on either of:
  - Busy=1 while in IDLE or LOAD;
  - Waiting=0 at the SEND cycle.
- Outputs Load, Sort, Send and Data_in are registered; latency from pop to Load high is 1 cycle.
- The FIFO keeps accepting input during sort and drain phases.

Optional Feature:
- SORT_TIMEOUT_EN:
  - Adds a 16-bit watchdog that counts cycles spent in WAIT_BUSY or WAIT_DONE.
  - At 0xFFFF it sets err and forces SEND; the vector is still counted.
- Without the macro, the FSM waits indefinitely and no watchdog logic is present.

Decomposition:
- Package sort_pkg holds:
  - the state enum;
  - WORD_SIZE_DEF=4 and VEC_LEN_DEF=8;
  - the watchdog limit constant.
- One sub-module: sort_feeder_fifo (synchronous FIFO with full/empty/count). The FSM stays in sort_feeder.

Test Plan:
- Stream 8 words 3,1,7,0,5,2,6,4 back-to-back with an ideal sorter model -> 8 consecutive Load cycles with Data_in in arrival order, one Sort pulse, one Send pulse, vec_done once, vec_count=1.
- Hold Ready=0 for 5 cycles after the 3rd Load -> Load stays low for those 5 cycles, then words 4..8 load; no err.
- Push 20 words with the sorter stalled in Busy -> in_ready falls after 16 entries; no word is lost; all 20 are later loaded, in order, across vectors 1..3.
- Assert rst during WAIT_DONE -> next cycle all outputs are at reset values and the FIFO is empty; a fresh 8-word stream completes normally.
- Sorter model drives Busy=1 while the feeder is IDLE -> err=1, and it stays 1 until rst.
- With SORT_TIMEOUT_EN, never assert Waiting -> after 65535 wait cycles err=1, Send pulses, and vec_count increments.
